// File: rtl/b1_arb_pkg.sv
// Shared types and the b1 core function for the round-robin b1 core arbiter.
// The core is purely combinational; the per-requester d state lives in the arbiter.
package b1_arb_pkg;

  localparam int B1_NUM_REQ_DEF = 4;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} arb_state_e;

  typedef struct packed {
    logic e;
    logic f;
    logic g;
  } b1_out_t;

  function automatic b1_out_t b1_eval(input logic a, input logic b, input logic d);
    b1_out_t o;
    o.e = a ^ b;
    o.f = d ? (~a & ~b) : (a & b);
    o.g = ~d;
    return o;
  endfunction

endpackage

// File: rtl/b1_rr_pick.sv
// Combinational round-robin picker: first valid index after 'last', wrapping to 0.
module b1_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_valid
);

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    // Search last+1 .. last+NUM_REQ so the previous winner has lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_valid && valid[ID_W'((int'(last) + i) % NUM_REQ)]) begin
        any_valid = 1'b1;
        idx       = ID_W'((int'(last) + i) % NUM_REQ);
        grant[ID_W'((int'(last) + i) % NUM_REQ)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/b1_core_arbiter.sv
// Round-robin sharing of one b1 core among NUM_REQ requesters, each with its own d bit.
// Define B1_ARB_FAST_ACCEPT_EN to accept the next request in the response-handshake cycle.
module b1_core_arbiter
  import b1_arb_pkg::*;
#(
  parameter int NUM_REQ = B1_NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_pad,
  input  logic               rst_pad,
  input  logic [NUM_REQ-1:0] req_valid_pad,
  input  logic [NUM_REQ-1:0] req_a_pad,
  input  logic [NUM_REQ-1:0] req_b_pad,
  output logic [NUM_REQ-1:0] req_ready_pad,
  output logic               rsp_valid_pad,
  output logic [ID_W-1:0]    rsp_id_pad,
  output logic               rsp_e_pad,
  output logic               rsp_f_pad,
  output logic               rsp_g_pad,
  input  logic               rsp_ready_pad,
  output logic [NUM_REQ-1:0] ctx_d_pad,
  output logic               busy_pad
);

  arb_state_e           state, state_nxt;
  logic [ID_W-1:0]      last_q, id_q, pick_idx;
  logic [NUM_REQ-1:0]   pick_grant, ctx_q, ctx_nxt;
  logic                 pick_any, accept, a_q, b_q;
  b1_out_t              core;

  b1_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid     (req_valid_pad),
    .last      (last_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign core = b1_eval(a_q, b_q, ctx_q[id_q]);

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    req_ready_pad = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          accept        = 1'b1;
          req_ready_pad = pick_grant;
          state_nxt     = EVAL;
        end
      end
      EVAL: state_nxt = RESP;
      RESP: begin
        if (rsp_ready_pad) begin
`ifdef B1_ARB_FAST_ACCEPT_EN
          if (pick_any) begin
            accept        = 1'b1;
            req_ready_pad = pick_grant;
            state_nxt     = EVAL;
          end else begin
            state_nxt     = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Each context bit only changes in the EVAL cycle of its own requester.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_ctx
    assign ctx_nxt[r] = (state == EVAL && id_q == ID_W'(r)) ? core.f : ctx_q[r];
  end

  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      state         <= IDLE;
      last_q        <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      a_q           <= 1'b0;
      b_q           <= 1'b0;
      ctx_q         <= '0;
      rsp_valid_pad <= 1'b0;
      rsp_id_pad    <= '0;
      rsp_e_pad     <= 1'b0;
      rsp_f_pad     <= 1'b0;
      rsp_g_pad     <= 1'b0;
    end else begin
      state <= state_nxt;
      ctx_q <= ctx_nxt;
      if (accept) begin
        a_q    <= req_a_pad[pick_idx];
        b_q    <= req_b_pad[pick_idx];
        id_q   <= pick_idx;
        last_q <= pick_idx;
      end
      if (state == EVAL) begin
        rsp_valid_pad <= 1'b1;
        rsp_id_pad    <= id_q;
        rsp_e_pad     <= core.e;
        rsp_f_pad     <= core.f;
        rsp_g_pad     <= core.g;
      end else if (state == RESP && rsp_ready_pad) begin
        rsp_valid_pad <= 1'b0;
      end
    end
  end

  assign ctx_d_pad = ctx_q;
  assign busy_pad  = (state != IDLE);

endmodule

// File: tb/tb_b1_core_arbiter.sv
// Scoreboard bench for b1_core_arbiter: reference model predicts grants and responses.
module tb_b1_core_arbiter;

  localparam int N = 4;
`ifdef B1_ARB_FAST_ACCEPT_EN
  localparam int GAP  = 2;
  localparam bit FAST = 1'b1;
`else
  localparam int GAP  = 3;
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_a, req_b, req_ready, ctx_d;
  logic         rsp_valid, rsp_ready, rsp_e, rsp_f, rsp_g, busy;
  logic [1:0]   rsp_id;

  always #5 clk = ~clk;

  b1_core_arbiter #(.NUM_REQ(N)) dut (
    .clk_pad       (clk),
    .rst_pad       (rst),
    .req_valid_pad (req_valid),
    .req_a_pad     (req_a),
    .req_b_pad     (req_b),
    .req_ready_pad (req_ready),
    .rsp_valid_pad (rsp_valid),
    .rsp_id_pad    (rsp_id),
    .rsp_e_pad     (rsp_e),
    .rsp_f_pad     (rsp_f),
    .rsp_g_pad     (rsp_g),
    .rsp_ready_pad (rsp_ready),
    .ctx_d_pad     (ctx_d),
    .busy_pad      (busy)
  );

  typedef struct {int id; bit e; bit f; bit g;} exp_t;
  exp_t sbq[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, can_acc_cyc = 0, m_last = N - 1;
  bit outstanding = 1'b0, rst_prev = 1'b0, measure = 1'b0;
  bit [N-1:0] m_ctx = '0;
  int n_acc = 0, last_grant = -1, prev_acc = -1;
  int grants[$];
  int got_id = 0;
  bit got_e, got_f, got_g;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (last + i) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int pack(input int id, input bit e, input bit f, input bit g);
    return (id << 3) | (int'(e) << 2) | (int'(f) << 1) | int'(g);
  endfunction

  // Response monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (rst_prev) begin
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ctx", int'(ctx_d), 0);
        chk("rst_rsp_fields", pack(int'(rsp_id), rsp_e, rsp_f, rsp_g), 0);
      end
      rst_prev    = 1'b1;
      sbq.delete();
      outstanding = 1'b0;
      m_ctx       = '0;
      m_last      = N - 1;
      can_acc_cyc = 0;
    end else begin
      rst_prev = 1'b0;
      cyc++;
      chk("rsp_valid", int'(rsp_valid), int'(outstanding && cyc >= acc_cyc + 2));
      chk("busy", int'(busy), int'(outstanding && cyc >= acc_cyc + 1));
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_fields", pack(int'(rsp_id), rsp_e, rsp_f, rsp_g),
              pack(sbq[0].id, sbq[0].e, sbq[0].f, sbq[0].g));
          if (rsp_ready) begin
            got_id = int'(rsp_id);
            got_e  = rsp_e;
            got_f  = rsp_f;
            got_g  = rsp_g;
            chk("ctx_after_rsp", int'(ctx_d), int'(m_ctx));
            void'(sbq.pop_front());
            outstanding = 1'b0;
            can_acc_cyc = FAST ? cyc : cyc + 1;
          end
        end
      end
    end
  end

  // Accept model: predicts the grant from the RR rule and pushes the expected response.
  always @(negedge clk) begin : acc_model
    int w, exp_rdy;
    bit a, b, d;
    exp_t ex;
    #1;
    if (!rst) begin
      w = -1;
      if (!outstanding && cyc >= can_acc_cyc) w = pick(req_valid, m_last);
      exp_rdy = (w >= 0) ? (1 << w) : 0;
      chk("req_ready", int'(req_ready), exp_rdy);
      if (w >= 0) begin
        d = m_ctx[w];
        a = req_a[w];
        b = req_b[w];
        ex.id = w;
        ex.e  = a ^ b;
        ex.f  = d ? (!a && !b) : (a && b);
        ex.g  = !d;
        sbq.push_back(ex);
        m_ctx[w]    = ex.f;
        m_last      = w;
        outstanding = 1'b1;
        acc_cyc     = cyc;
        last_grant  = w;
        grants.push_back(w);
        n_acc++;
        if (measure) begin
          if (prev_acc >= 0) chk("accept_gap", cyc - prev_acc, GAP);
          prev_acc = cyc;
        end
      end
    end
  end

  task automatic wait_acc(input int n);
    int base;
    base = n_acc;
    for (int k = 0; k < 80 && n_acc < base + n; k++) begin
      @(posedge clk); #1;
    end
    if (n_acc < base + n) chk("accept_timeout", n_acc - base, n);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80 && (outstanding || sbq.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    if (outstanding || sbq.size() != 0) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_one(input int idx, input bit a, input bit b);
    req_valid = N'(1 << idx);
    req_a     = N'(int'(a) << idx);
    req_b     = N'(int'(b) << idx);
    wait_acc(1);
    req_valid = '0;
    wait_idle();
  endtask

  task automatic check_last(input string nm, input int id, input bit e, input bit f, input bit g);
    chk(nm, pack(got_id, got_e, got_f, got_g), pack(id, e, f, g));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // requester 0 alone walks its context bit through the core
    send_one(0, 1'b1, 1'b1); check_last("r0_t1", 0, 0, 1, 1); chk("r0_t1_ctx", int'(ctx_d[0]), 1);
    send_one(0, 1'b1, 1'b1); check_last("r0_t2", 0, 0, 0, 0); chk("r0_t2_ctx", int'(ctx_d[0]), 0);
    send_one(0, 1'b0, 1'b0); check_last("r0_t3", 0, 0, 0, 1); chk("r0_t3_ctx", int'(ctx_d[0]), 0);
    send_one(0, 1'b1, 1'b0); check_last("r0_t4", 0, 1, 0, 1);

    // all requesters continuously valid after reset
    do_reset();
    grants.delete(); measure = 1'b1; prev_acc = -1;
    req_a = '1; req_b = '1; req_valid = '1;
    wait_acc(4);
    req_valid = '0; measure = 1'b0;
    wait_idle();
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_order", grants[i], i);
    chk("rr_ctx", int'(ctx_d), 4'b1111);

    // back-pressure with other requesters waiting
    rsp_ready = 1'b0;
    req_valid = 4'b0010; req_a = '0; req_b = 4'b0010;
    wait_acc(1);
    req_valid = '1;
    repeat (7) @(posedge clk);
    #1 rsp_ready = 1'b1; req_valid = '0;
    wait_idle();

    // reset while a transaction is in EVAL
    send_one(2, 1'b1, 1'b1);
    req_valid = 4'b1000;
    wait_acc(1);
    rst = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctx", int'(ctx_d), 0);
    @(posedge clk); #1;
    req_valid = '1;
    wait_acc(1);
    req_valid = '0;
    chk("post_rst_grant", last_grant, 0);
    wait_idle();

    // randomized traffic and back-pressure
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      req_a     = N'($urandom);
      req_b     = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = '0; rsp_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/b1_core_arbiter.md
Name: b1_core_arbiter

Overview:
- Shares one b1 combinational core (e = a^b; f = d ? (~a&~b) : (a&b); g = ~d) among NUM_REQ requesters by round-robin arbitration.
- Holds one private state bit d per requester (context) and updates it from the core's f output after each evaluation, turning the combinational core into a per-requester sequential b1 machine.
- Sits between requester ports and a single registered response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the response id field.

Ports:
- clk_pad  in  1  clock; all logic on the rising edge.
- rst_pad  in  1  reset: synchronous, active-high.
- req_valid_pad  in  NUM_REQ  per-requester request valid.
- req_a_pad  in  NUM_REQ  per-requester operand a.
- req_b_pad  in  NUM_REQ  per-requester operand b.
- req_ready_pad  out  NUM_REQ  one-hot accept strobe; combinational.
- rsp_valid_pad  out  1  response valid.
- rsp_id_pad  out  ID_W  index of the requester being answered.
- rsp_e_pad  out  1  core e output.
- rsp_f_pad  out  1  core f output.
- rsp_g_pad  out  1  core g output.
- rsp_ready_pad  in  1  response consumer ready.
- ctx_d_pad  out  NUM_REQ  current context bits (observability).
- busy_pad  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - all rsp_* = 0; ctx_d all 0; busy = 0; FSM = IDLE.
  - RR pointer last = NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid, pick winner w = first valid index searching last+1 .. last+NUM_REQ, modulo NUM_REQ.
  - req_ready[w] = 1 in the same cycle; all other ready bits stay 0; the handshake completes in that cycle.
  - Latch a_q, b_q, id_q = w; set last <= w; go to EVAL.
  - If no request is valid, stay in IDLE with req_ready = 0.
- EVAL:
  - Compute the core from a_q, b_q and ctx_d[id_q].
  - Register e/f/g/id into the rsp_* registers; set rsp_valid <= 1.
  - Update ctx_d[id_q] <= f; go to RESP.
  - req_ready = 0.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0; no new accepts.
  - When rsp_ready=1: clear rsp_valid and go to IDLE.
- Latency: accept at cycle T, rsp_valid first high at T+2. Throughput: one transaction per 3 cycles when the consumer is always ready.
- ctx_d update occurs once per accepted request, independent of response back-pressure.
- Requester protocol: a deasserted valid is simply not considered. No requirement that valid be held, since acceptance is single-cycle.
- Simultaneous requests: exactly one grant per accept cycle. Fairness: a continuously requesting index is served within NUM_REQ grants.
- Wrap-around: RR search wraps from NUM_REQ-1 to 0.
- Reset mid-operation: any in-flight transaction is dropped with no response. ctx_d and the RR pointer return to their reset values.
- rsp_e/f/g/id retain their last values after the handshake until overwritten (rsp_valid qualifies them).

Optional Feature:
- B1_ARB_FAST_ACCEPT_EN defined:
  - In RESP with rsp_ready=1, if any req_valid, perform the IDLE arbitration and accept in the same cycle and go directly to EVAL.
  - Back-to-back throughput becomes one transaction per 2 cycles.
  - busy stays high across back-to-back transactions.
- Undefined: RESP always returns to IDLE first (3-cycle throughput).
- Reset values, grant order and latency from accept are identical in both builds.

Decomposition:
- Package b1_arb_pkg:
  - state enum {IDLE, EVAL, RESP};
  - function b1_eval(a, b, d) returning {e, f, g};
  - localparam default NUM_REQ.
- Sub-module b1_rr_pick: combinational round-robin picker. Inputs: valid vector and last pointer. Outputs: one-hot grant, encoded index, any_valid.

Test Plan:
- Reset → all outputs 0, ctx_d=0000, busy=0. First request by requester 0 only (a=1, b=1) → rsp at T+2: id=0, e=0, f=1, g=1; ctx_d[0]=1.
- Repeat requester 0 (a=1, b=1, d=1) → e=0, f=0, g=0; ctx_d[0]=0. Then a=0, b=0 → e=0, f=0, g=1, ctx_d[0] stays 0. Then a=1, b=0 → e=1, f=0, g=1.
- All four requesters valid continuously (a=1, b=1) → grants in order 0,1,2,3,0. Each first response has f=1, g=1; ctx_d=1111 after four transactions.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req_ready=0 throughout. Release → rsp_valid drops in the next cycle and the next accept follows in IDLE.
- Assert rst_pad in EVAL → no response produced; ctx_d=0; next grant goes to requester 0 even if last was 2.
- With B1_ARB_FAST_ACCEPT_EN and the consumer always ready → accepts every 2 cycles; without it, every 3 cycles.
